// File: rtl/tft_spi_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tft_spi_transmitter
//  Function : Byte-wide SPI mode-0 transmitter for the TFT panel. A one-byte
//             holding register keeps SCK continuous across back-to-back bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tft_spi_transmitter #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tft_transmit,
   input  logic [7:0] tft_data,
   input  logic       tft_dc,
   output logic       tft_busy,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_cs_n,
   output logic       spi_dc,
   output logic       byte_done,
   output logic       drop_err
);

   localparam int                 c_div_w   = $clog2(CLK_DIV + 1);
   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(CLK_DIV - 1);

   localparam logic [1:0] c_idle   = 2'd0;
   localparam logic [1:0] c_setup  = 2'd1;
   localparam logic [1:0] c_shift  = 2'd2;
   localparam logic [1:0] c_cshold = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [c_div_w-1:0] div_q, div_d;
   logic [2:0]         bit_q, bit_d;
   logic [6:0]         shift_q, shift_d;
   logic [7:0]         hold_data_q, hold_data_d;
   logic               hold_dc_q, hold_dc_d;
   logic               hold_valid_q, hold_valid_d;
   logic               sck_q, sck_d;
   logic               mosi_q, mosi_d;
   logic               cs_n_q, cs_n_d;
   logic               dc_q, dc_d;
   logic               done_q, done_d;
   logic               drop_q, drop_d;

   logic               w_tick;
   logic               w_load;
   logic               w_accept;

   assign w_tick = (div_q == c_div_max);

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      hold_data_d  = hold_data_q;
      hold_dc_d    = hold_dc_q;
      hold_valid_d = hold_valid_q;
      sck_d        = sck_q;
      mosi_d       = mosi_q;
      cs_n_d       = cs_n_q;
      dc_d         = dc_q;
      done_d       = 1'b0;
      drop_d       = drop_q;
      w_load       = 1'b0;
      w_accept     = 1'b0;

      case (state_q)
         c_idle: begin
            w_load = hold_valid_q;
         end
         c_setup: begin
            if (w_tick) begin
               div_d   = '0;
               sck_d   = 1'b1;
               state_d = c_shift;
            end else begin
               div_d = div_q + c_div_w'(1);
            end
         end
         c_shift: begin
            if (w_tick) begin
               div_d = '0;
               sck_d = ~sck_q;
               // Falling edge: present the next bit, or close out the byte.
               if (sck_q) begin
                  if (bit_q == 3'd7) begin
                     done_d = 1'b1;
                     bit_d  = '0;
                     if (hold_valid_q) begin
                        w_load = 1'b1;
                     end else begin
                        state_d = c_cshold;
                     end
                  end else begin
                     bit_d   = bit_q + 3'd1;
                     mosi_d  = shift_q[6];
                     shift_d = {shift_q[5:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + c_div_w'(1);
            end
         end
         default: begin
            if (w_tick) begin
               div_d   = '0;
               cs_n_d  = 1'b1;
               state_d = c_idle;
            end else begin
               div_d = div_q + c_div_w'(1);
            end
         end
      endcase

      if (w_load) begin
         shift_d      = hold_data_q[6:0];
         mosi_d       = hold_data_q[7];
         dc_d         = hold_dc_q;
         cs_n_d       = 1'b0;
         div_d        = '0;
         bit_d        = '0;
         state_d      = c_setup;
         hold_valid_d = 1'b0;
      end

      // A register being emptied this edge may be refilled on the same edge.
      w_accept = tft_transmit & (~hold_valid_q | w_load);
      if (w_accept) begin
         hold_data_d  = tft_data;
         hold_dc_d    = tft_dc;
         hold_valid_d = 1'b1;
      end else if (tft_transmit) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= c_idle;
         div_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         hold_data_q  <= '0;
         hold_dc_q    <= 1'b0;
         hold_valid_q <= 1'b0;
         sck_q        <= 1'b0;
         mosi_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         dc_q         <= 1'b0;
         done_q       <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         hold_data_q  <= hold_data_d;
         hold_dc_q    <= hold_dc_d;
         hold_valid_q <= hold_valid_d;
         sck_q        <= sck_d;
         mosi_q       <= mosi_d;
         cs_n_q       <= cs_n_d;
         dc_q         <= dc_d;
         done_q       <= done_d;
         drop_q       <= drop_d;
      end
   end

   assign tft_busy  = hold_valid_q;
   assign spi_sck   = sck_q;
   assign spi_mosi  = mosi_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_dc    = dc_q;
   assign byte_done = done_q;
   assign drop_err  = drop_q;

endmodule
`default_nettype wire
